// File: rtl/square_osc_pkg.sv
// Shared tone/period definitions: oscillator state encoding and the default
// shortest playable period.
package square_osc_pkg;

  localparam int MIN_PERIOD_DEFAULT = 2;

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2
  } osc_state_t;

endpackage

// File: rtl/square_osc_period_split.sv
// Splits a full-cycle period into high and low phase lengths; an odd period
// gives the extra clock to the low phase.
module period_split #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] hi_len,
  output logic [WIDTH-1:0] lo_len
);

  assign hi_len = p >> 1;
  assign lo_len = p - hi_len;

endmodule

// File: rtl/square_osc.sv
// Phase-continuous square-wave oscillator: period and silencing changes are
// only accepted at the end of a full waveform cycle.
//
// state  | meaning
// SILENT | no oscillation, wave low, waiting for a playable period
// HIGH   | high phase of the current cycle, cnt counts down hi_len-1..0
// LOW    | low phase, cnt counts down lo_len-1..0; terminal clk decides next cycle
module square_osc
  import square_osc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] period,
  input  logic             enable,
  output logic             wave,
  output logic             active,
  output logic             cycle_start,
  output logic [WIDTH-1:0] cur_period
);

  osc_state_t       state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] per, per_n;
  logic [WIDTH-1:0] lo_len, lo_len_n;
  logic [WIDTH-1:0] new_hi, new_lo;
  logic             start_n;
  logic             wave_q, start_q;
  logic             playable;

  period_split #(.WIDTH(WIDTH)) u_split (
    .p      (period),
    .hi_len (new_hi),
    .lo_len (new_lo)
  );

  assign playable = enable && (period >= WIDTH'(MIN_PERIOD));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    per_n    = per;
    lo_len_n = lo_len;
    start_n  = 1'b0;
    case (state)
      SILENT: begin
        if (playable) begin
          state_n  = HIGH;
          per_n    = period;
          lo_len_n = new_lo;
          cnt_n    = new_hi - WIDTH'(1);
          start_n  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_n = LOW;
          cnt_n   = lo_len - WIDTH'(1);
        end else begin
          cnt_n = cnt - WIDTH'(1);
        end
      end
      LOW: begin
        if (cnt != '0) begin
          cnt_n = cnt - WIDTH'(1);
        end else if (playable) begin
          state_n  = HIGH;
          per_n    = period;
          lo_len_n = new_lo;
          cnt_n    = new_hi - WIDTH'(1);
          start_n  = 1'b1;
        end else begin
          state_n = SILENT;
          per_n   = '0;
        end
      end
      default: begin
        state_n = SILENT;
        cnt_n   = '0;
        per_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SILENT;
      cnt     <= '0;
      per     <= '0;
      lo_len  <= '0;
      wave_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      per     <= per_n;
      lo_len  <= lo_len_n;
      wave_q  <= (state_n == HIGH);
      start_q <= start_n;
    end
  end

  assign wave        = wave_q;
  assign cycle_start = start_q;
  assign active      = (state != SILENT);
  assign cur_period  = per;

endmodule

// File: tb/tb_square_osc.sv
// Scoreboard bench for square_osc (WIDTH=8): expected per-clock outputs are
// queued from the period split rules and compared at each falling edge.
module tb_square_osc;

  localparam int W = 8;

  typedef struct packed {
    logic         wave;
    logic         cs;
    logic         act;
    logic [W-1:0] cur;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] period = '0;
  logic         enable = 1'b0;
  logic         wave, active, cycle_start;
  logic [W-1:0] cur_period;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  square_osc #(.WIDTH(W), .MIN_PERIOD(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .period      (period),
    .enable      (enable),
    .wave        (wave),
    .active      (active),
    .cycle_start (cycle_start),
    .cur_period  (cur_period)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    return '{wave: wave, cs: cycle_start, act: active, cur: cur_period};
  endfunction

  function automatic void push_cycle(int p);
    int hi = p / 2;
    for (int i = 0; i < p; i++)
      exp_q.push_back('{wave: (i < hi), cs: (i == 0), act: 1'b1, cur: W'(p)});
  endfunction

  function automatic void push_silent(int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{wave: 1'b0, cs: 1'b0, act: 1'b0, cur: '0});
  endfunction

  // Leaves the DUT silent just after a falling edge with the given inputs applied.
  task automatic restart(input int p, input logic en);
    @(negedge clk);
    rst = 1'b1; period = '0; enable = 1'b0;
    @(negedge clk);
    rst = 1'b0; period = W'(p); enable = en;
  endtask

  task automatic test_reset();
    exp_t o, e;
    #1;
    o = observed();
    e = '0;
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", o, e);
    end
    // async reset in the middle of a HIGH phase
    restart(8, 1'b1);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    o = observed();
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", o, e);
    end
    @(negedge clk);
    rst = 1'b0; period = W'(4); enable = 1'b1;
    exp_q.delete();
    push_cycle(4); push_cycle(4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observed();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_release: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_steady();
    exp_t o, e;
    int plist[3] = '{4, 5, 2};
    foreach (plist[k]) begin
      restart(plist[k], 1'b1);
      exp_q.delete();
      for (int c = 0; c < 3; c++) push_cycle(plist[k]);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        o = observed();
        n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL steady_p%0d: got %h want %h", plist[k], o, e);
        end
      end
    end
  endtask

  task automatic test_period_change();
    exp_t o, e;
    int i = 0;
    restart(4, 1'b1);
    exp_q.delete();
    push_cycle(4); push_cycle(6); push_cycle(6);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observed();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL period_change[%0d]: got %h want %h", i, o, e);
      end
      if (i == 0) period = W'(6);
      i++;
    end
  endtask

  task automatic test_stop();
    exp_t o, e;
    for (int v = 0; v < 3; v++) begin
      int i = 0;
      restart((v == 2) ? 1 : 8, 1'b1);
      exp_q.delete();
      if (v != 2) push_cycle(8);
      push_silent(6);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        o = observed();
        n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL stop_v%0d[%0d]: got %h want %h", v, i, o, e);
        end
        if (i == 0 && v == 0) enable = 1'b0;
        if (i == 0 && v == 1) period = '0;
        i++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    int i = 0;
    restart(4, 1'b1);
    exp_q.delete();
    push_cycle(4); push_silent(1); push_cycle(4); push_cycle(4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observed();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL restart_gap[%0d]: got %h want %h", i, o, e);
      end
      if (i == 2) enable = 1'b0;
      if (i == 4) enable = 1'b1;
      i++;
    end
  endtask

  task automatic test_max_period();
    exp_t o, e;
    int i = 0;
    int hi_cnt = 0;
    restart(255, 1'b1);
    exp_q.delete();
    push_cycle(255); push_silent(3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observed();
      if (o.wave === 1'b1) hi_cnt++;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL max_period[%0d]: got %h want %h", i, o, e);
      end
      if (i == 0) period = '0;
      i++;
    end
    n_cmp++;
    if (hi_cnt != 127) begin
      n_bad++;
      $display("FAIL max_high_len: got %0d want 127", hi_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_period_change();
    test_stop();
    test_back_to_back();
    test_max_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/square_osc.md
# square_osc

Phase-continuous square-wave oscillator that turns the note period (in clock cycles) from the tone lookup into a 1-bit audio waveform for the speaker/PWM output pin. Sits directly downstream of the tone-to-period decoder. Period changes and silencing take effect only at a waveform-cycle boundary, so note changes never produce runt pulses or clicks.

## Interface

- WIDTH, 32, width of the period input and internal counter
- MIN_PERIOD, 2, smallest period that is played; any smaller value, including 0, means silent
- clk  input  1  system clock (25 MHz in the standard build)
- rst  input  1  asynchronous, active-high reset
- period  input  WIDTH  requested full-cycle period in clk cycles; 0 = silent
- enable  input  1  gate; low requests silence at the next cycle boundary
- wave  output  1  square-wave audio output, registered
- active  output  1  high while an oscillation cycle is in progress (state != SILENT)
- cycle_start  output  1  one-cycle pulse on the first clk of every waveform cycle
- cur_period  output  WIDTH  period latched for the cycle currently playing; 0 when silent

## Operation

- States: SILENT, HIGH, LOW. Down-counter cnt has WIDTH bits. Latched registers: per, hi_len, lo_len.
- Split of the latched period p: hi_len = p >> 1 and lo_len = p - hi_len. For an odd p, the low phase gets the extra cycle.
- "Playable" means enable=1 and period >= MIN_PERIOD, sampled on the current edge.
- SILENT: wave=0, active=0, cur_period=0.
  - If playable, latch per=period, go to HIGH, load cnt=hi_len-1, and assert wave=1 and cycle_start=1 on that edge.
- HIGH: wave=1.
  - If cnt==0, go to LOW and load cnt=lo_len-1. Otherwise decrement cnt.
- LOW: wave=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0 and the input is playable, re-latch per=period and go to HIGH with cycle_start=1. Back-to-back cycles have no gap.
  - If cnt==0 and the input is not playable, go to SILENT.
- Changes to period or enable in the middle of a cycle are ignored until the LOW-phase terminal cycle. The cycle in progress always completes with the old per.
- Period values above MIN_PERIOD have no upper limit. The maximum 2^WIDTH-1 must work without overflow; hi_len and lo_len are computed in WIDTH bits.

## Timing

- Reset values: wave=0, active=0, cycle_start=0, cur_period=0, state=SILENT, cnt=0.
- Reset asserted mid-cycle forces all of the above immediately and asynchronously. The first cycle after reset release follows the SILENT rules.
- Latency from SILENT: period becomes playable before edge N, so wave=1 and cycle_start=1 are visible after edge N (1 clk).
- For a steady period p, wave has exactly hi_len clks high and lo_len clks low. cycle_start pulses every p clks.
- cur_period updates on the same edge as cycle_start and holds for the whole cycle.
- Stopping: silence requested at any point in cycle k means wave=0 and active=0 from the end of cycle k onward. The last cycle is never truncated.
- Boundary case: period becomes playable on the same edge that LOW terminates with the input unplayable. The next sampled edge decides. There is no combinational path from period to wave.

## Structure

- The tone/period shared package holds MIN_PERIOD_DEFAULT and the osc_state_t enum (SILENT, HIGH, LOW). The tone decoder and this block both import it.
- Single module. An optional sub-module, period_split, is combinational and computes hi_len and lo_len from p. Keep it separate so it can be reused by a future PWM-duty variant.

## Test plan

- Reset, then period=4, enable=1: wave = 1,1,0,0 repeating. cycle_start every 4th clk. cur_period=4.
- period=5: 2 clks high, 3 clks low. cycle_start spacing 5. period=2: alternating 1,0.
- Playing period=4, switch to period=6 during the HIGH phase: the current cycle finishes as 1,1,0,0, the next cycle is 1,1,1,0,0,0, and cur_period changes to 6 on that cycle_start.
- Playing period=8, drop enable (or set period=0) on the 2nd clk: the full 4-high/4-low cycle completes, then wave=0, active=0, cur_period=0 with no further pulses. period=1 never starts oscillation.
- Assert rst in the middle of the HIGH phase: wave=0, active=0, cycle_start=0 immediately. Release with period=4: the first high starts 1 clk after release.
- period=2^WIDTH-1 with a reduced-WIDTH build (WIDTH=8, period=255): 127 clks high, 128 clks low, no counter wrap.
